// File: rtl/sal_sched_pkg.sv
// rtl/sal_sched_pkg.sv - shared command/state types for the multi-bank scheduler
package sal_sched_pkg;

    typedef enum logic [1:0] {
        BK_ACT = 2'd0,
        BK_RD  = 2'd1,
        BK_WR  = 2'd2,
        BK_PRE = 2'd3
    } bk_cmd_e;

    typedef enum logic [2:0] {
        SCHED_NOP = 3'd0,
        SCHED_ACT = 3'd1,
        SCHED_RD  = 3'd2,
        SCHED_WR  = 3'd3,
        SCHED_PRE = 3'd4,
        SCHED_REF = 3'd5
    } sched_cmd_e;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_DRAIN = 2'd1,
        RS_REF   = 2'd2,
        RS_WAIT  = 2'd3
    } ref_state_e;

    // Bank-side command encoding to DFI-side command encoding
    function automatic sched_cmd_e to_sched_cmd(input bk_cmd_e c);
        case (c)
            BK_ACT:  return SCHED_ACT;
            BK_RD:   return SCHED_RD;
            BK_WR:   return SCHED_WR;
            default: return SCHED_PRE;
        endcase
    endfunction

endpackage

// File: rtl/sal_rr_arbiter.sv
// rtl/sal_rr_arbiter.sv - round-robin arbiter, search starts at ptr_i and wraps N-1 -> 0
module sal_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // First requester found scanning upward from the pointer wins
    always_comb begin
        logic [IW-1:0] b;
        b       = '0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            b = IW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[b]) begin
                valid_o  = 1'b1;
                gnt_o[b] = 1'b1;
                idx_o    = b;
            end
        end
    end

endmodule

// File: rtl/sal_bk_sched.sv
// rtl/sal_bk_sched.sv - multi-bank DDR2 command scheduler; refresh engine under SAL_SCHED_REFRESH_EN
module sal_bk_sched
    import sal_sched_pkg::*;
#(
    parameter int BK_CNT      = 4,
    parameter int BA_WIDTH    = 2,
    parameter int RA_WIDTH    = 14,
    parameter int CA_WIDTH    = 10,
    parameter int TIMER_WIDTH = 8,
    parameter int REFI_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TIMER_WIDTH-1:0]     t_rrd_i,
    input  logic [TIMER_WIDTH-1:0]     t_ccd_i,
    input  logic [TIMER_WIDTH-1:0]     t_rfc_i,
    input  logic [REFI_WIDTH-1:0]      t_refi_i,
    input  logic [BK_CNT-1:0]          bk_req_valid_i,
    input  logic [2*BK_CNT-1:0]        bk_req_cmd_i,
    input  logic [RA_WIDTH*BK_CNT-1:0] bk_req_ra_i,
    input  logic [CA_WIDTH*BK_CNT-1:0] bk_req_ca_i,
    output logic [BK_CNT-1:0]          bk_req_gnt_o,
    output logic                       ref_req_o,
    input  logic [BK_CNT-1:0]          bk_ref_ack_i,
    output logic                       sched_valid_o,
    output logic [2:0]                 sched_cmd_o,
    output logic [BA_WIDTH-1:0]        sched_ba_o,
    output logic [RA_WIDTH-1:0]        sched_ra_o,
    output logic [CA_WIDTH-1:0]        sched_ca_o
);

    localparam logic [BA_WIDTH-1:0] LAST_BK = BA_WIDTH'(BK_CNT - 1);

    // Spacing of 0 or 1 means no stall, so the counter never wraps below zero
    function automatic logic [TIMER_WIDTH-1:0] spacing_load(input logic [TIMER_WIDTH-1:0] t);
        return (t == '0) ? '0 : t - TIMER_WIDTH'(1);
    endfunction

    ref_state_e                 ref_state;
    logic                       act_ok, cas_ok;
    logic [BA_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
    logic [TIMER_WIDTH-1:0]     rrd_cnt_q, rrd_cnt_d, ccd_cnt_q, ccd_cnt_d;
    logic [BK_CNT-1:0]          cas_req, row_req, cas_gnt, row_gnt;
    logic [BA_WIDTH-1:0]        cas_idx, row_idx, gnt_idx;
    logic                       cas_any, row_any, gnt_any;
    logic [1:0]                 sel_cmd_raw;
    bk_cmd_e                    sel_cmd;
    logic [RA_WIDTH-1:0]        sel_ra;
    logic [CA_WIDTH-1:0]        sel_ca;
    logic                       sched_valid_q, sched_valid_d;
    sched_cmd_e                 sched_cmd_q, sched_cmd_d;
    logic [BA_WIDTH-1:0]        sched_ba_q, sched_ba_d;
    logic [RA_WIDTH-1:0]        sched_ra_q, sched_ra_d;
    logic [CA_WIDTH-1:0]        sched_ca_q, sched_ca_d;

    // ACT only when no refresh is in progress; CAS/PRE may still run while banks drain
    assign act_ok = (ref_state == RS_IDLE);
    assign cas_ok = (ref_state == RS_IDLE) || (ref_state == RS_DRAIN);

    // Split requests into CAS class and row class, applying spacing and refresh gating
    always_comb begin
        cas_req = '0;
        row_req = '0;
        for (int b = 0; b < BK_CNT; b++) begin
            case (bk_cmd_e'(bk_req_cmd_i[2*b +: 2]))
                BK_RD, BK_WR: cas_req[b] = bk_req_valid_i[b] && (ccd_cnt_q == '0) && cas_ok;
                BK_ACT:       row_req[b] = bk_req_valid_i[b] && (rrd_cnt_q == '0) && act_ok;
                default:      row_req[b] = bk_req_valid_i[b] && cas_ok;
            endcase
        end
    end

    sal_rr_arbiter #(.N(BK_CNT), .IW(BA_WIDTH)) u_cas_arb (
        .req_i   (cas_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (cas_gnt),
        .idx_o   (cas_idx),
        .valid_o (cas_any)
    );

    sal_rr_arbiter #(.N(BK_CNT), .IW(BA_WIDTH)) u_row_arb (
        .req_i   (row_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (row_gnt),
        .idx_o   (row_idx),
        .valid_o (row_any)
    );

    // CAS class wins over row class whenever it has any eligible requester
    assign gnt_any      = cas_any | row_any;
    assign gnt_idx      = cas_any ? cas_idx : row_idx;
    assign bk_req_gnt_o = cas_any ? cas_gnt : row_gnt;

    // Pick the granted bank's command and addresses through the one-hot grant
    always_comb begin
        sel_cmd_raw = '0;
        sel_ra      = '0;
        sel_ca      = '0;
        for (int b = 0; b < BK_CNT; b++) begin
            if (bk_req_gnt_o[b]) begin
                sel_cmd_raw = bk_req_cmd_i[2*b +: 2];
                sel_ra      = bk_req_ra_i[RA_WIDTH*b +: RA_WIDTH];
                sel_ca      = bk_req_ca_i[CA_WIDTH*b +: CA_WIDTH];
            end
        end
    end
    assign sel_cmd = bk_cmd_e'(sel_cmd_raw);

    // Round-robin pointer advance and tRRD/tCCD spacing counters
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        rrd_cnt_d = (rrd_cnt_q == '0) ? '0 : rrd_cnt_q - TIMER_WIDTH'(1);
        ccd_cnt_d = (ccd_cnt_q == '0) ? '0 : ccd_cnt_q - TIMER_WIDTH'(1);
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == LAST_BK) ? '0 : gnt_idx + BA_WIDTH'(1);
            if (sel_cmd == BK_ACT) begin
                rrd_cnt_d = spacing_load(t_rrd_i);
            end
            if (sel_cmd == BK_RD || sel_cmd == BK_WR) begin
                ccd_cnt_d = spacing_load(t_ccd_i);
            end
        end
    end

    // Next DFI command: granted request, else REF while in the REF state, else NOP
    always_comb begin
        sched_valid_d = 1'b0;
        sched_cmd_d   = SCHED_NOP;
        sched_ba_d    = '0;
        sched_ra_d    = '0;
        sched_ca_d    = '0;
        if (gnt_any) begin
            sched_valid_d = 1'b1;
            sched_cmd_d   = to_sched_cmd(sel_cmd);
            sched_ba_d    = gnt_idx;
            sched_ra_d    = sel_ra;
            sched_ca_d    = sel_ca;
        end else if (ref_state == RS_REF) begin
            sched_valid_d = 1'b1;
            sched_cmd_d   = SCHED_REF;
        end
    end

    // Arbitration state and registered command output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            rrd_cnt_q     <= '0;
            ccd_cnt_q     <= '0;
            sched_valid_q <= 1'b0;
            sched_cmd_q   <= SCHED_NOP;
            sched_ba_q    <= '0;
            sched_ra_q    <= '0;
            sched_ca_q    <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            rrd_cnt_q     <= rrd_cnt_d;
            ccd_cnt_q     <= ccd_cnt_d;
            sched_valid_q <= sched_valid_d;
            sched_cmd_q   <= sched_cmd_d;
            sched_ba_q    <= sched_ba_d;
            sched_ra_q    <= sched_ra_d;
            sched_ca_q    <= sched_ca_d;
        end
    end

    assign sched_valid_o = sched_valid_q;
    assign sched_cmd_o   = sched_cmd_q;
    assign sched_ba_o    = sched_ba_q;
    assign sched_ra_o    = sched_ra_q;
    assign sched_ca_o    = sched_ca_q;

`ifdef SAL_SCHED_REFRESH_EN
    ref_state_e             ref_state_q, ref_state_d;
    logic [REFI_WIDTH-1:0]  refi_cnt_q, refi_cnt_d;
    logic [TIMER_WIDTH-1:0] rfc_cnt_q, rfc_cnt_d;
    logic                   pend_q, pend_d;
    logic                   refi_expire;

    // Free-running refresh interval counter; t_refi_i of zero parks it at zero
    always_comb begin
        refi_expire = 1'b0;
        refi_cnt_d  = refi_cnt_q + REFI_WIDTH'(1);
        if (t_refi_i == '0) begin
            refi_cnt_d = '0;
        end else if (refi_cnt_q == t_refi_i - REFI_WIDTH'(1)) begin
            refi_expire = 1'b1;
            refi_cnt_d  = '0;
        end
    end

    // Refresh sequencing: drain banks, issue REF, hold off for tRFC; one refresh may be postponed
    always_comb begin
        ref_state_d = ref_state_q;
        pend_d      = pend_q;
        rfc_cnt_d   = (rfc_cnt_q == '0) ? '0 : rfc_cnt_q - TIMER_WIDTH'(1);
        if (refi_expire && ref_state_q != RS_IDLE) begin
            pend_d = 1'b1;
        end
        case (ref_state_q)
            RS_IDLE: begin
                if (refi_expire || pend_q) begin
                    ref_state_d = RS_DRAIN;
                    pend_d      = 1'b0;
                end
            end
            RS_DRAIN: begin
                if (&bk_ref_ack_i) begin
                    ref_state_d = RS_REF;
                end
            end
            RS_REF: begin
                ref_state_d = RS_WAIT;
                rfc_cnt_d   = spacing_load(t_rfc_i);
            end
            RS_WAIT: begin
                if (rfc_cnt_q == '0) begin
                    ref_state_d = RS_IDLE;
                end
            end
            default: ref_state_d = RS_IDLE;
        endcase
    end

    // Refresh state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_state_q <= RS_IDLE;
            refi_cnt_q  <= '0;
            rfc_cnt_q   <= '0;
            pend_q      <= 1'b0;
        end else begin
            ref_state_q <= ref_state_d;
            refi_cnt_q  <= refi_cnt_d;
            rfc_cnt_q   <= rfc_cnt_d;
            pend_q      <= pend_d;
        end
    end

    assign ref_state = ref_state_q;
    assign ref_req_o = (ref_state_q != RS_IDLE);
`else
    logic unused_refresh_inputs;

    assign ref_state             = RS_IDLE;
    assign ref_req_o             = 1'b0;
    assign unused_refresh_inputs = ^{t_rfc_i, t_refi_i, bk_ref_ack_i};
`endif

endmodule

// File: tb/tb_sal_bk_sched.sv
// tb/tb_sal_bk_sched.sv - self-checking bench for sal_bk_sched
module tb_sal_bk_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  t_rrd, t_ccd, t_rfc;
    logic [15:0] t_refi;
    logic [3:0]  valid;
    logic [7:0]  cmd;
    logic [55:0] ra;
    logic [39:0] ca;
    logic [3:0]  gnt;
    logic        ref_req;
    logic [3:0]  ack;
    logic        s_valid;
    logic [2:0]  s_cmd;
    logic [1:0]  s_ba;
    logic [13:0] s_ra;
    logic [9:0]  s_ca;

    int n_tests = 0;
    int n_fail  = 0;

    sal_bk_sched dut (
        .clk            (clk),
        .rst            (rst),
        .t_rrd_i        (t_rrd),
        .t_ccd_i        (t_ccd),
        .t_rfc_i        (t_rfc),
        .t_refi_i       (t_refi),
        .bk_req_valid_i (valid),
        .bk_req_cmd_i   (cmd),
        .bk_req_ra_i    (ra),
        .bk_req_ca_i    (ca),
        .bk_req_gnt_o   (gnt),
        .ref_req_o      (ref_req),
        .bk_ref_ack_i   (ack),
        .sched_valid_o  (s_valid),
        .sched_cmd_o    (s_cmd),
        .sched_ba_o     (s_ba),
        .sched_ra_o     (s_ra),
        .sched_ca_o     (s_ca)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        valid = '0;
        ack   = '0;
        #1;
        chk("reset_outputs", {gnt, ref_req, s_valid, s_cmd, s_ba, s_ra, s_ca}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] valid;
        logic [7:0] cmd;
        logic [7:0] t_rrd;
        logic [7:0] t_ccd;
        logic [3:0] gnt;
        logic [2:0] ocmd;
        logic [1:0] oba;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [3:0] v, logic [7:0] c, logic [7:0] rrd, logic [7:0] ccd,
                                logic [3:0] g, logic [2:0] oc, logic [1:0] ob);
        vec_t x;
        x.rst = r; x.valid = v; x.cmd = c; x.t_rrd = rrd; x.t_ccd = ccd;
        x.gnt = g; x.ocmd = oc; x.oba = ob;
        return x;
    endfunction

    // Reference model state (arbitration only; refresh held off with t_refi=0)
    int          m_ptr, m_rrd, m_ccd;
    logic        e_valid;
    logic [2:0]  e_cmd;
    logic [1:0]  e_ba;
    logic [13:0] e_ra;
    logic [9:0]  e_ca;

    function automatic int bank_cmd(input logic [7:0] c, input int b);
        return int'((c >> (2*b)) & 8'h3);
    endfunction

    function automatic int pick_winner();
        int w = -1;
        for (int k = 0; k < 4; k++) begin
            int b = (m_ptr + k) % 4;
            int c = bank_cmd(cmd, b);
            if (w < 0 && valid[b] && (c == 1 || c == 2) && m_ccd == 0) w = b;
        end
        for (int k = 0; k < 4; k++) begin
            int b = (m_ptr + k) % 4;
            int c = bank_cmd(cmd, b);
            if (w < 0 && valid[b] && ((c == 0 && m_rrd == 0) || c == 3)) w = b;
        end
        return w;
    endfunction

    initial begin
        int n, bad, w, c;
        rst = 1'b1; t_rrd = 1; t_ccd = 1; t_rfc = 1; t_refi = 0;
        valid = '0; cmd = '0; ack = '0;
        for (int b = 0; b < 4; b++) begin
            ra[14*b +: 14] = 14'(100 + b);
            ca[10*b +: 10] = 10'(20 + b);
        end

        // RD beats ACT; ACT follows next cycle
        vecs.push_back(mk(1, 4'b0101, 8'h01, 1, 4, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 8'h00, 1, 4, 4'b0100, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 8'h00, 1, 4, 4'b0000, 1, 2));
        // four ACTs, tRRD=3: grants every third cycle in bank order
        for (int c2 = 0; c2 <= 10; c2++)
            vecs.push_back(mk(c2 == 0, 4'b1111, 8'h00, 3, 1,
                              (c2 % 3 == 0) ? 4'(1 << (c2 / 3)) : 4'b0000,
                              (c2 >= 1 && (c2 - 1) % 3 == 0) ? 3'd1 : 3'd0,
                              (c2 >= 1 && (c2 - 1) % 3 == 0) ? 2'((c2 - 1) / 3) : 2'd0));
        // banks 1 and 3 RD, tCCD=2: alternate every two cycles
        for (int c2 = 0; c2 <= 8; c2++)
            vecs.push_back(mk(c2 == 0, 4'b1010, 8'h44, 1, 2,
                              (c2 % 2 == 0) ? (((c2 / 2) % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000,
                              (c2 % 2 == 1) ? 3'd2 : 3'd0,
                              (c2 % 2 == 1) ? (((c2 - 1) / 2 % 2 == 0) ? 2'd1 : 2'd3) : 2'd0));
        // PRE not held by tRRD while a blocked ACT waits
        vecs.push_back(mk(1, 4'b0001, 8'h00, 4, 1, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 4'b0110, 8'h30, 4, 1, 4'b0100, 1, 0));
        vecs.push_back(mk(0, 4'b0010, 8'h00, 4, 1, 4'b0000, 4, 2));
        vecs.push_back(mk(0, 4'b0010, 8'h00, 4, 1, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0010, 8'h00, 4, 1, 4'b0010, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 8'h00, 4, 1, 4'b0000, 1, 1));
        // tRRD=0 back-to-back ACTs; WR overrides pointer-order ACT
        vecs.push_back(mk(1, 4'b1111, 8'h00, 0, 0, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 8'h00, 0, 0, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 8'h80, 0, 0, 4'b1000, 1, 1));
        vecs.push_back(mk(0, 4'b0001, 8'h00, 0, 0, 4'b0001, 3, 3));
        vecs.push_back(mk(0, 4'b0000, 8'h00, 0, 0, 4'b0000, 1, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            else @(negedge clk);
            t_rrd = vecs[i].t_rrd;
            t_ccd = vecs[i].t_ccd;
            valid = vecs[i].valid;
            cmd   = vecs[i].cmd;
            #1;
            chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
            chk($sformatf("vec%0d_out", i), {s_valid, s_cmd, s_ba},
                {(vecs[i].ocmd != 3'd0), vecs[i].ocmd, vecs[i].oba});
        end

        // Randomized traffic against the reference model
        t_refi = 0;
        do_reset();
        m_ptr = 0; m_rrd = 0; m_ccd = 0;
        e_valid = 0; e_cmd = 0; e_ba = 0; e_ra = 0; e_ca = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 100 == 0) begin
                t_rrd = 8'($urandom_range(0, 5));
                t_ccd = 8'($urandom_range(0, 5));
            end
            valid = 4'($urandom);
            cmd   = 8'($urandom);
            ra    = {24'($urandom), 32'($urandom)};
            ca    = {8'($urandom), 32'($urandom)};
            #1;
            w = pick_winner();
            chk($sformatf("rnd%0d_gnt", cyc), gnt, (w < 0) ? 4'b0000 : 4'(1 << w));
            chk($sformatf("rnd%0d_out", cyc), {ref_req, s_valid, s_cmd, s_ba, s_ra, s_ca},
                {1'b0, e_valid, e_cmd, e_ba, e_ra, e_ca});
            if (m_rrd > 0) m_rrd--;
            if (m_ccd > 0) m_ccd--;
            if (w >= 0) begin
                c       = bank_cmd(cmd, w);
                e_valid = 1'b1;
                e_cmd   = 3'(c + 1);
                e_ba    = 2'(w);
                e_ra    = 14'(ra >> (14 * w));
                e_ca    = 10'(ca >> (10 * w));
                m_ptr   = (w + 1) % 4;
                if (c == 0) m_rrd = (t_rrd > 0) ? int'(t_rrd) - 1 : 0;
                if (c == 1 || c == 2) m_ccd = (t_ccd > 0) ? int'(t_ccd) - 1 : 0;
            end else begin
                e_valid = 0; e_cmd = 0; e_ba = 0; e_ra = 0; e_ca = 0;
            end
            @(negedge clk);
        end
        valid = '0;

`ifdef SAL_SCHED_REFRESH_EN
        // First refresh 100 cycles after reset, acks 5 cycles later, tRFC hold-off
        t_refi = 100; t_rfc = 10; t_rrd = 1; t_ccd = 1; cmd = 8'h55;
        do_reset();
        n = 0;
        while (!ref_req && n < 300) begin @(negedge clk); n++; end
        chk("refi_first", n, 100);
        repeat (5) @(negedge clk);
        ack = 4'hF;
        @(negedge clk);
        chk("ref_state_quiet", {ref_req, s_valid}, 2'b10);
        @(negedge clk);
        chk("ref_issue", {s_valid, s_cmd, s_ba, s_ra, s_ca}, {1'b1, 3'd5, 2'd0, 14'd0, 10'd0});
        valid = 4'hF;
        #1;
        n = 0; bad = 0;
        while (ref_req && n < 50) begin
            if (gnt !== 4'b0000) bad++;
            @(negedge clk); #1; n++;
        end
        chk("rfc_wait_len", n, 10);
        chk("rfc_no_grants", bad, 0);
        chk("post_ref_grant", gnt, 4'b0001);
        valid = '0;

        // Postponed refresh: expiry during a long drain re-enters DRAIN right after WAIT
        ack = '0;
        do_reset();
        n = 0;
        while (!ref_req && n < 300) begin @(negedge clk); n++; end
        chk("refi_second", n, 100);
        repeat (150) @(negedge clk);
        ack = 4'hF;
        n = 0;
        while (ref_req && n < 100) begin @(negedge clk); n++; end
        chk("pend_idle_gap", ref_req, 1'b0);
        @(negedge clk);
        chk("pend_redrain", ref_req, 1'b1);

        // Asynchronous reset in the middle of WAIT
        @(negedge clk);
        @(negedge clk);
        chk("wait_ref_out", {s_valid, s_cmd}, {1'b1, 3'd5});
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {gnt, ref_req, s_valid, s_cmd, s_ba, s_ra, s_ca}, 64'd0);
        @(negedge clk);
        rst = 1'b0; ack = '0;
        n = 0;
        while (!ref_req && n < 300) begin @(negedge clk); n++; end
        chk("refi_after_rst", n, 100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
